// File: rtl/selector_scheduler.sv
// Round-robin slot scheduler for a shared registered 4:1 selector datapath.
// Grants one requester lane at a time for at most HOLD_CYCLES cycles and flags valid datapath samples.
module selector_scheduler #(
  parameter int HOLD_CYCLES = 4,
  parameter int CNT_W       = 8
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_enable,
  input  logic [3:0] i_req,
  output logic [1:0] o_selector,
  output logic [3:0] o_grant,
  output logic       o_busy,
  output logic       o_sample,
  output logic       o_slot_done
);

  localparam logic [0:0]       ST_IDLE    = 1'b0;
  localparam logic [0:0]       ST_GRANT   = 1'b1;
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(HOLD_CYCLES - 1);

  // Returns {found, index}: first set request bit scanning ptr, ptr+1, ... modulo 4.
  function automatic logic [2:0] rr_pick(input logic [1:0] ptr, input logic [3:0] req);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int k = 3; k >= 0; k--) begin
      idx = ptr + 2'(k);
      if (req[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  logic [0:0]       state, state_nx;
  logic [1:0]       ptr, ptr_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [3:0]       grant_nx;
  logic [1:0]       sel_nx;
  logic             done_nx;
  logic             sample_nx;
  logic             rel;
  logic [3:0]       req_masked;
  logic [1:0]       next_ptr;
  logic [2:0]       pick_idle;
  logic [2:0]       pick_rel;

  assign req_masked = i_req & {4{i_enable}};
  // While granting, the selector register always holds the granted index.
  assign next_ptr   = o_selector + 2'd1;
  assign pick_idle  = rr_pick(ptr, req_masked);
  assign pick_rel   = rr_pick(next_ptr, req_masked);

  always_comb begin
    state_nx = state;
    ptr_nx   = ptr;
    cnt_nx   = cnt;
    grant_nx = o_grant;
    sel_nx   = o_selector;
    done_nx  = 1'b0;
    rel      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (pick_idle[2]) begin
          state_nx = ST_GRANT;
          grant_nx = 4'b0001 << pick_idle[1:0];
          sel_nx   = pick_idle[1:0];
          cnt_nx   = CNT_RELOAD;
        end
      end
      ST_GRANT: begin
        rel = (cnt == '0) || !i_req[o_selector];
        if (rel) begin
          ptr_nx  = next_ptr;
          done_nx = 1'b1;
          if (pick_rel[2]) begin
            grant_nx = 4'b0001 << pick_rel[1:0];
            sel_nx   = pick_rel[1:0];
            cnt_nx   = CNT_RELOAD;
          end else begin
            state_nx = ST_IDLE;
            grant_nx = 4'b0000;
            cnt_nx   = '0;
          end
        end else begin
          cnt_nx = cnt - 1'b1;
        end
      end
      default: begin
        state_nx = ST_IDLE;
        grant_nx = 4'b0000;
        cnt_nx   = '0;
      end
    endcase
    // Datapath output lags the selector by one register, so a lane is valid only once held two edges.
    sample_nx = (grant_nx != 4'b0000) && (grant_nx == o_grant);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= ST_IDLE;
      ptr         <= 2'd0;
      cnt         <= '0;
      o_grant     <= 4'b0000;
      o_selector  <= 2'd0;
      o_busy      <= 1'b0;
      o_sample    <= 1'b0;
      o_slot_done <= 1'b0;
    end else begin
      state       <= state_nx;
      ptr         <= ptr_nx;
      cnt         <= cnt_nx;
      o_grant     <= grant_nx;
      o_selector  <= sel_nx;
      o_busy      <= (grant_nx != 4'b0000);
      o_sample    <= sample_nx;
      o_slot_done <= done_nx;
    end
  end

endmodule

// File: doc/selector_scheduler.md
Name: selector_scheduler

Overview:
Round-robin controller that shares the registered 4:1 selector datapath (4-bit data, 2-bit selector, registered 1-bit output) among four requesters. Each requester owns one data-bit lane. The block drives the datapath selector and grants each active requester a time slot of bounded length. It also flags the cycles in which the datapath's registered output reflects the granted lane. It sits between the requesters and the datapath's selector input, on the same clock.

Parameters:
HOLD_CYCLES, 4, maximum grant length in clock cycles per slot; legal range 2..255.
CNT_W, 8, width of the internal slot counter; must hold HOLD_CYCLES-1.

Ports:
i_clk  input  1  clock; all logic updates on the rising edge.
i_rst  input  1  synchronous, active-high reset.
i_enable  input  1  permits new grants; does not abort a grant in progress.
i_req  input  4  request vector; bit n = requester n wants lane n.
o_selector  output  2  selector value driven to the datapath.
o_grant  output  4  one-hot grant; all zero when idle.
o_busy  output  1  high while a slot is active (o_grant != 0).
o_sample  output  1  high when the datapath output equals the data bit of the granted lane.
o_slot_done  output  1  one-cycle pulse in the first cycle after a slot ends.

Behaviour:
- Reset values (i_rst high at an edge):
  - o_selector=0, o_grant=0, o_busy=0, o_sample=0, o_slot_done=0.
  - Priority pointer=0, counter=0, state=IDLE.
  - Reset mid-slot aborts the slot immediately; no o_slot_done pulse.
- All outputs are registered.
- Two states: IDLE and GRANT.
- IDLE:
  - Condition: i_enable=1 and i_req!=0 sampled at edge t.
  - Winner: first set bit scanning pointer, pointer+1, ... modulo 4.
  - After edge t: state=GRANT, o_grant=onehot(winner), o_selector=winner, o_busy=1, counter=HOLD_CYCLES-1.
  - Otherwise stay in IDLE; o_selector holds its last value.
- GRANT, at each edge:
  - Release condition: counter==0, or i_req[granted]==0 (early release).
  - No release: counter decrements.
  - Release:
    - pointer=(granted+1) mod 4; o_slot_done=1 for the next cycle.
    - Re-arbitration uses the new pointer and the current i_req, masked by i_enable.
    - Winner exists: go back-to-back into a new GRANT in the same edge, with no idle cycle and the counter reloaded.
    - No winner: go to IDLE with o_grant=0 and o_busy=0.
    - A single requester requesting continuously is re-granted back-to-back. Its slot still ends and o_slot_done still pulses.
- Counter expiry and request drop at the same edge: a single release and a single o_slot_done pulse.
- i_enable low during GRANT: the current slot runs to its normal release, then goes to IDLE with no regrant.
- o_sample:
  - Asserted after edge t+1 when o_grant was nonzero with the same index after both edge t and edge t+1. This accounts for the datapath's one-cycle register latency.
  - It is low in the first cycle of every slot, including back-to-back slots that change index.
  - A back-to-back regrant to the same index keeps o_sample high.
  - A full slot of HOLD_CYCLES cycles gives HOLD_CYCLES-1 o_sample cycles.
- o_slot_done is never high in two consecutive cycles unless slots of length 1 occur through early release.

Test Plan:
- Reset: hold i_rst for 2 cycles while i_req=4'b1111 -> all outputs 0; after release, the first grant is o_grant=0001 and o_selector=0.
- Single requester, HOLD_CYCLES=4: i_req=4'b0100 held one cycle only after edge t -> o_grant=0100 and o_selector=2 for 1 cycle; o_slot_done at the next cycle; then IDLE. Held continuously -> 4-cycle slots back-to-back, o_sample high except the first cycle of the run.
- Round-robin fairness: i_req=4'b1011 constant -> grant order 0,1,3,0,1,3, each slot 4 cycles; o_slot_done pulses every 4 cycles; o_sample low in the first cycle of each slot.
- Early release: grant lane 1, drop i_req[1] during the 2nd grant cycle -> slot ends at the next edge; pointer=2; the pending requester 3 is granted with no idle cycle.
- Enable gating: deassert i_enable mid-slot with i_req=4'b1111 -> the current slot completes its 4 cycles, then o_grant=0 and o_busy=0. Reassert i_enable -> the next grant goes to the lane after the last winner.
- Datapath integration: connect to the datapath with i_data=4'b1001 and i_req=4'b1111 -> the datapath output is 1,0,0,1 during the o_sample cycles of lanes 0,1,2,3.
